uart_tx_arbiter: RTL and testbench

- Shares a single uart_tx transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.
- Supports an optional lock, so one requester can send a multi-byte message without other bytes interleaving.
- Sequences the transmitter's begin/busy/done handshake.
- Sits between the LCD/debug message sources and the one UART TX pin driver.

---
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte streams, with optional per-owner lock
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [NUM_REQ-1:0]     i_reqValid,
  input  logic [8*NUM_REQ-1:0]   i_reqData,
  input  logic [NUM_REQ-1:0]     i_reqLock,
  output logic [NUM_REQ-1:0]     o_reqAccept,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_txBegin,
  output logic [7:0]             o_txData,
  input  logic                   i_txBusy,
  input  logic                   i_txDone,
  output logic                   o_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {ARB, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, owner_q, owner_d;
  logic                 lock_q, lock_d, begin_q, begin_d, busy_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, accept_q, accept_d;
  logic [7:0]           data_q, data_d;
  logic [IW-1:0]        win, idx, nxt, who;
  logic                 issue;
  // descending scan so the last hit is the nearest set bit at or above the pointer
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (i_reqValid[idx]) win = idx;
    end
    nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    who = (state_q == HOLD) ? owner_q : win;
    issue = !i_txBusy && ((state_q == ARB && |i_reqValid) || (state_q == HOLD && i_reqValid[owner_q]));
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    accept_d = '0;
    begin_d  = 1'b0;
    data_d   = data_q;
    if (issue) begin
      state_d  = WAIT_BUSY;
      owner_d  = who;
      grant_d  = NUM_REQ'(1) << who;
      accept_d = NUM_REQ'(1) << who;
      begin_d  = 1'b1;
      data_d   = i_reqData[8*who +: 8];
      lock_d   = i_reqLock[who];
      cnt_d    = '0;
    end else begin
      case (state_q)
        WAIT_BUSY: state_d = i_txBusy ? WAIT_DONE : WAIT_BUSY;
        WAIT_DONE: if (i_txDone) begin
          state_d = lock_q ? HOLD : ARB;
          cnt_d   = '0;
          ptr_d   = lock_q ? ptr_q : nxt;
          grant_d = lock_q ? grant_q : '0;
        end
        HOLD: if (cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          state_d = ARB;
          ptr_d   = nxt;
          grant_d = '0;
          lock_d  = 1'b0;
        end else cnt_d = cnt_q + 16'd1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      lock_q   <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= '0;
      accept_q <= '0;
      begin_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      accept_q <= accept_d;
      begin_q  <= begin_d;
      data_q   <= data_d;
      busy_q   <= (state_d != ARB);
    end
  end
  assign o_reqAccept = accept_q;
  assign o_grant     = grant_q;
  assign o_txBegin   = begin_q;
  assign o_txData    = data_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a queued requester driver and a simple non-resettable uart_tx model
module tb_uart_tx_arbiter;
  localparam int NUM = 4;
  localparam int LT = 20;
  localparam int FRAME = 40;
  logic i_clock = 1'b0;
  logic i_reset_n = 1'b0;
  logic [NUM-1:0] i_reqValid, i_reqLock, o_reqAccept, o_grant;
  logic [8*NUM-1:0] i_reqData;
  logic o_txBegin, i_txBusy, i_txDone, o_busy;
  logic [7:0] o_txData;
  int checks = 0;
  int errors = 0;
  always #5 i_clock = ~i_clock;
  uart_tx_arbiter #(.NUM_REQ(NUM), .LOCK_TIMEOUT(LT)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_reqValid(i_reqValid), .i_reqData(i_reqData),
    .i_reqLock(i_reqLock), .o_reqAccept(o_reqAccept), .o_grant(o_grant), .o_txBegin(o_txBegin),
    .o_txData(o_txData), .i_txBusy(i_txBusy), .i_txDone(i_txDone), .o_busy(o_busy)
  );
  // uart_tx stand-in: no reset, busy for FRAME cycles, done pulses as busy falls
  logic busy_m = 1'b0;
  logic done_m = 1'b0;
  int cnt_m = 0;
  logic [7:0] txlog [64];
  int ntx = 0;
  assign i_txBusy = busy_m;
  assign i_txDone = done_m;
  always @(posedge i_clock) begin
    done_m <= 1'b0;
    if (busy_m) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin
        busy_m <= 1'b0;
        done_m <= 1'b1;
      end
    end else if (o_txBegin) begin
      busy_m <= 1'b1;
      cnt_m <= FRAME;
      txlog[ntx] <= o_txData;
      ntx <= ntx + 1;
    end
  end
  logic [8:0] qmem [NUM][16];
  int head [NUM] = '{0, 0, 0, 0};
  int tail [NUM] = '{0, 0, 0, 0};
  task automatic push(input int k, input logic [7:0] b, input logic l);
    qmem[k][tail[k]] = {l, b};
    tail[k]++;
  endtask
  function automatic logic q_empty();
    for (int k = 0; k < NUM; k++) if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction
  initial begin
    i_reqValid = '0;
    i_reqData = '0;
    i_reqLock = '0;
    forever begin
      @(negedge i_clock);
      for (int k = 0; k < NUM; k++) begin
        if (o_reqAccept[k] && head[k] < tail[k]) head[k]++;
        i_reqValid[k] = head[k] < tail[k];
        i_reqData[8*k +: 8] = (head[k] < tail[k]) ? qmem[k][head[k]][7:0] : 8'h00;
        i_reqLock[k] = (head[k] < tail[k]) ? qmem[k][head[k]][8] : 1'b0;
      end
    end
  end
  int acclog [64];
  int nacc = 0;
  logic prev_b = 1'b0;
  initial forever begin
    @(posedge i_clock);
    #1;
    if (o_txBegin) begin
      checks++;
      if (prev_b || i_txBusy || $countones(o_reqAccept) != 1) begin
        errors++;
        $display("FAIL begin_pulse: prev=%0b busy=%0b accept=%b, required prev=0 busy=0 one-hot accept", prev_b, i_txBusy, o_reqAccept);
      end
    end
    prev_b = o_txBegin;
    for (int k = 0; k < NUM; k++) if (o_reqAccept[k]) begin
      acclog[nacc] = k;
      nacc++;
    end
  end
  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(posedge i_clock);
    #1;
    while ((o_busy || busy_m || !q_empty()) && n < 3000) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", tag, n);
    end
  endtask
  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    checks++;
    if ({o_grant, o_reqAccept, o_txBegin, o_txData, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b accept=%b begin=%b data=%h busy=%b, required all 0", o_grant, o_reqAccept, o_txBegin, o_txData, o_busy);
    end
    i_reset_n = 1'b1;
    @(posedge i_clock);
    #1;
  endtask
  task automatic test_single();
    int nt = ntx;
    int n = 0;
    push(1, 8'h41, 1'b0);
    @(posedge i_clock);
    #1;
    checks++;
    if (o_txBegin !== 1'b1 || o_txData !== 8'h41 || o_reqAccept !== 4'b0010 || o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_issue: begin=%b data=%h accept=%b grant=%b, required 1 41 0010 0010", o_txBegin, o_txData, o_reqAccept, o_grant);
    end
    @(posedge i_clock);
    #1;
    checks++;
    if (o_txBegin !== 1'b0 || o_reqAccept !== 4'b0000 || o_grant !== 4'b0010 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after: begin=%b accept=%b grant=%b busy=%b, required 0 0000 0010 1", o_txBegin, o_reqAccept, o_grant, o_busy);
    end
    while (!done_m && n < 200) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant_hold: grant=%b at done (n=%0d), required 0010", o_grant, n);
    end
    @(posedge i_clock);
    #1;
    checks++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b, required 0000 0", o_grant, o_busy);
    end
    checks++;
    if (ntx !== nt + 1 || txlog[nt] !== 8'h41) begin
      errors++;
      $display("FAIL single_line: frames=%0d byte=%h, required 1 41", ntx - nt, txlog[nt]);
    end
  endtask
  task automatic test_round_robin();
    int nt, na;
    i_reset_n = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;
    nt = ntx;
    na = nacc;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM; k++) push(k, 8'hA0 + 8'(k), 1'b0);
    wait_idle("rr");
    for (int i = 0; i < 2 * NUM; i++) begin
      checks++;
      if (acclog[na+i] !== i % NUM || txlog[nt+i] !== 8'hA0 + 8'(i % NUM)) begin
        errors++;
        $display("FAIL rr_order[%0d]: req=%0d byte=%h, required req=%0d byte=%h", i, acclog[na+i], txlog[nt+i], i % NUM, 8'hA0 + 8'(i % NUM));
      end
    end
  endtask
  task automatic test_lock();
    int nt = ntx;
    int na = nacc;
    int n = 0;
    logic [7:0] exp_b [4] = '{8'h10, 8'h11, 8'h12, 8'h55};
    int exp_r [4] = '{2, 2, 2, 0};
    push(2, 8'h10, 1'b1);
    push(2, 8'h11, 1'b1);
    push(2, 8'h12, 1'b0);
    while (nacc == na && n < 50) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    push(0, 8'h55, 1'b0);
    wait_idle("lock");
    checks++;
    if (ntx - nt !== 4) begin
      errors++;
      $display("FAIL lock_count: frames=%0d, required 4", ntx - nt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txlog[nt+i] !== exp_b[i] || acclog[na+i] !== exp_r[i]) begin
        errors++;
        $display("FAIL lock_order[%0d]: req=%0d byte=%h, required req=%0d byte=%h", i, acclog[na+i], txlog[nt+i], exp_r[i], exp_b[i]);
      end
    end
  endtask
  task automatic test_timeout();
    int na = nacc;
    int n = 0;
    push(3, 8'h77, 1'b1);
    while (nacc == na && n < 50) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    push(1, 8'h31, 1'b0);
    n = 0;
    while (!done_m && n < 200) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    for (int i = 0; i < 22; i++) begin
      @(posedge i_clock);
      #1;
      if (i == 0 || i == 19) begin
        checks++;
        if (o_grant !== 4'b1000 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL timeout_hold[%0d]: grant=%b busy=%b, required 1000 1", i, o_grant, o_busy);
        end
      end
      if (i == 20) begin
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL timeout_release: grant=%b busy=%b, required 0000 0", o_grant, o_busy);
        end
      end
      if (i == 21) begin
        checks++;
        if (o_grant !== 4'b0010 || o_reqAccept !== 4'b0010 || o_txData !== 8'h31) begin
          errors++;
          $display("FAIL timeout_next: grant=%b accept=%b data=%h, required 0010 0010 31", o_grant, o_reqAccept, o_txData);
        end
      end
    end
    wait_idle("timeout");
  endtask
  task automatic test_reset_mid_frame();
    int nt = ntx;
    int n = 0;
    logic seen_done = 1'b0;
    push(0, 8'h5A, 1'b0);
    while (!busy_m && n < 50) begin
      @(posedge i_clock);
      #1;
      n++;
    end
    repeat (18) @(posedge i_clock);
    #1;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_grant, o_reqAccept, o_txBegin, o_txData, o_busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b accept=%b begin=%b data=%h busy=%b, required all 0", o_grant, o_reqAccept, o_txBegin, o_txData, o_busy);
    end
    repeat (2) @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;
    push(1, 8'h66, 1'b0);
    n = 0;
    while (!o_txBegin && n < 200) begin
      @(posedge i_clock);
      #1;
      if (done_m) seen_done = 1'b1;
      n++;
    end
    checks++;
    if (seen_done !== 1'b1 || o_txBegin !== 1'b1) begin
      errors++;
      $display("FAIL midreset_wait: begin=%b old_frame_done=%b, required 1 1", o_txBegin, seen_done);
    end
    wait_idle("midreset");
    checks++;
    if (ntx - nt !== 2 || txlog[nt] !== 8'h5A || txlog[nt+1] !== 8'h66) begin
      errors++;
      $display("FAIL midreset_line: frames=%0d bytes=%h %h, required 2 5a 66", ntx - nt, txlog[nt], txlog[nt+1]);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
